// File: rtl/decoder_pkg.sv
// Shared field-position helpers and the MOV opcode constant for the instruction decoder.
// The functions take the widths so that parametrised instances locate fields the same way.
package decoder_pkg;

   localparam int DEF_REG_ADDR_W = 2;
   localparam int DEF_OPCODE_W   = 3;

   function automatic int illegal_bit(input int opcode_w, input int reg_addr_w);
      return opcode_w + reg_addr_w;
   endfunction

   function automatic int opcode_lsb(input int reg_addr_w);
      return reg_addr_w;
   endfunction

   // The all-ones opcode is MOV; every other opcode is an ALU op.
   function automatic int mov_opcode(input int opcode_w);
      return (2 ** opcode_w) - 1;
   endfunction

   localparam int ILLEGAL_BIT = illegal_bit(DEF_OPCODE_W, DEF_REG_ADDR_W);
   localparam int OPCODE_LSB  = opcode_lsb(DEF_REG_ADDR_W);

   typedef struct packed {
      logic [DEF_OPCODE_W-1:0]        opcode;
      logic                           aku;
      logic [DEF_REG_ADDR_W-1:0]      addr;
      logic [2**DEF_REG_ADDR_W-1:0]   we;
      logic                           illegal;
   } decoded_t;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register write-back scoreboard: tracks MOV writes still in flight and flags a
// read-after-write hazard for the incoming ALU read address.
module decode_scoreboard #(
   parameter int  REG_ADDR_W = 2,
   parameter int  WB_LAT     = 2,
   localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REGS-1:0]   issue_we,
   input  logic [NUM_REGS-1:0]   pend_we,
   input  logic                  rd_en,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  hazard
);

   logic busy_hit;

   generate
      if (WB_LAT > 0) begin : g_cnt
         localparam int CNT_W = $clog2(WB_LAT + 1);

         logic [CNT_W-1:0] busy_q [NUM_REGS];
         logic [CNT_W-1:0] busy_d [NUM_REGS];

         // NOTE: a fresh issue reloads the counter even if it is still counting down.
         always_comb begin
            for (int n = 0; n < NUM_REGS; n++) begin
               busy_d[n] = busy_q[n];
               if (issue_we[n]) begin
                  busy_d[n] = CNT_W'(WB_LAT);
               end else if (busy_q[n] != '0) begin
                  busy_d[n] = busy_q[n] - CNT_W'(1);
               end
            end
         end

         // NOTE: the counters are a small flop array, not RAM, so clearing them on reset is cheap and required.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int n = 0; n < NUM_REGS; n++) begin
                  busy_q[n] <= '0;
               end
            end else begin
               busy_q <= busy_d;
            end
         end

         assign busy_hit = (busy_q[rd_addr] != '0);
      end else begin : g_no_cnt
         logic unused_sb;
         assign unused_sb = ^{clk, rst, issue_we};
         assign busy_hit  = 1'b0;
      end
   endgenerate

   assign hazard = rd_en && (busy_hit || pend_we[rd_addr]);

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered instruction decoder with valid/ready handshake and RAW-hazard stalling.
// Optional macro DEC_STALL_CNT_EN adds a saturating 16-bit stall_count output.
module instruction_decode_stage
   import decoder_pkg::*;
#(
   parameter int  REG_ADDR_W = 2,
   parameter int  OPCODE_W   = 3,
   parameter int  WB_LAT     = 2,
   localparam int INSTR_W    = 1 + OPCODE_W + REG_ADDR_W,
   localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INSTR_W-1:0]    instruction,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OPCODE_W-1:0]   operation_code,
   output logic                  aku_enable,
   output logic [REG_ADDR_W-1:0] register_addr,
   output logic [NUM_REGS-1:0]   reg_write_enable,
   output logic                  illegal
`ifdef DEC_STALL_CNT_EN
   ,
   output logic [15:0]           stall_count
`endif
);

   localparam int                ILL_BIT = illegal_bit(OPCODE_W, REG_ADDR_W);
   localparam int                OPC_LSB = opcode_lsb(REG_ADDR_W);
   localparam logic [OPCODE_W-1:0] MOV_OP = OPCODE_W'(mov_opcode(OPCODE_W));

   typedef struct packed {
      logic [OPCODE_W-1:0]   opcode;
      logic                  aku;
      logic [REG_ADDR_W-1:0] addr;
      logic [NUM_REGS-1:0]   we;
      logic                  illegal;
   } dec_word_t;

   dec_word_t dec_in, dec_d, dec_q;
   logic      out_valid_d, out_valid_q;
   logic      hazard, accept, out_hs;

   always_comb begin
      dec_in         = '0;
      dec_in.illegal = instruction[ILL_BIT];
      dec_in.opcode  = instruction[OPC_LSB +: OPCODE_W];
      dec_in.addr    = instruction[REG_ADDR_W-1:0];
      if (!dec_in.illegal) begin
         if (dec_in.opcode == MOV_OP) begin
            dec_in.we = NUM_REGS'(1) << dec_in.addr;
         end else begin
            dec_in.aku = 1'b1;
         end
      end
   end

   // A word sitting in the output register counts as pending until it handshakes.
   decode_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .WB_LAT     (WB_LAT)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .issue_we (out_hs ? dec_q.we : '0),
      .pend_we  (out_valid_q ? dec_q.we : '0),
      .rd_en    (dec_in.aku),
      .rd_addr  (dec_in.addr),
      .hazard   (hazard)
   );

   assign out_hs   = out_valid_q && out_ready;
   assign in_ready = !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      dec_d       = dec_q;
      if (accept) begin
         out_valid_d = 1'b1;
         dec_d       = dec_in;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         dec_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         dec_q       <= dec_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign operation_code   = dec_q.opcode;
   assign aku_enable       = dec_q.aku;
   assign register_addr    = dec_q.addr;
   assign reg_write_enable = dec_q.we;
   assign illegal          = dec_q.illegal;

`ifdef DEC_STALL_CNT_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_valid && hazard && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed plan steps followed by
// randomized traffic, all compared against a cycle-indexed behavioural model.
module tb_instruction_decode_stage;

   localparam int WB_LAT = 2;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, out_valid, out_ready, aku_enable, illegal;
   logic [5:0] instruction;
   logic [2:0] operation_code;
   logic [1:0] register_addr;
   logic [3:0] reg_write_enable;
`ifdef DEC_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   instruction_decode_stage #(
      .REG_ADDR_W (2),
      .OPCODE_W   (3),
      .WB_LAT     (WB_LAT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .instruction      (instruction),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .operation_code   (operation_code),
      .aku_enable       (aku_enable),
      .register_addr    (register_addr),
      .reg_write_enable (reg_write_enable),
      .illegal          (illegal)
`ifdef DEC_STALL_CNT_EN
      ,
      .stall_count      (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int cyc    = 0;

   // Model: output register contents plus the cycle each register's last MOV issued.
   bit         m_valid;
   logic [5:0] m_instr;
   int         last_issue [4];
   int         m_stalls;

   // Values observed at the most recent step's sampling point.
   logic        o_rdy, o_ov, o_aku, o_ill;
   logic [2:0]  o_opc;
   logic [1:0]  o_addr;
   logic [3:0]  o_we;
   logic [15:0] o_sc;

   function automatic bit f_ill(input logic [5:0] i);
      return (i >> 5) != 0;
   endfunction
   function automatic int f_opc(input logic [5:0] i);
      return (i >> 2) & 7;
   endfunction
   function automatic int f_reg(input logic [5:0] i);
      return i & 3;
   endfunction
   function automatic bit f_mov(input logic [5:0] i);
      return !f_ill(i) && f_opc(i) == 7;
   endfunction
   function automatic bit f_alu(input logic [5:0] i);
      return !f_ill(i) && f_opc(i) != 7;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_instr  = '0;
      m_stalls = 0;
      for (int r = 0; r < 4; r++) last_issue[r] = -1000;
   endtask

   task automatic step(input bit r, input bit v, input logic [5:0] ins, input bit ordy, input bit chk);
      bit haz, exp_rdy, hs;
      int rr;
      @(negedge clk);
      rst = r; in_valid = v; instruction = ins; out_ready = ordy;
      #1;
      rr      = f_reg(ins);
      haz     = f_alu(ins) && ((cyc - last_issue[rr] <= WB_LAT) ||
                               (m_valid && f_mov(m_instr) && f_reg(m_instr) == rr));
      exp_rdy = !haz && (!m_valid || ordy);
      o_rdy = in_ready; o_ov = out_valid; o_aku = aku_enable; o_ill = illegal;
      o_opc = operation_code; o_addr = register_addr; o_we = reg_write_enable;
`ifdef DEC_STALL_CNT_EN
      o_sc = stall_count;
`else
      o_sc = '0;
`endif
      if (chk) begin
         check("in_ready", in_ready, exp_rdy);
         check("out_valid", out_valid, m_valid);
         if (m_valid) begin
            check("operation_code", operation_code, f_opc(m_instr));
            check("aku_enable", aku_enable, f_alu(m_instr));
            check("register_addr", register_addr, f_reg(m_instr));
            check("reg_write_enable", reg_write_enable, f_mov(m_instr) ? (1 << f_reg(m_instr)) : 0);
            check("illegal", illegal, f_ill(m_instr));
         end
`ifdef DEC_STALL_CNT_EN
         check("stall_count", stall_count, m_stalls);
`endif
      end
      if (r) begin
         model_reset();
      end else begin
         hs = m_valid && ordy;
         if (hs && f_mov(m_instr)) last_issue[f_reg(m_instr)] = cyc;
         if (v && haz) m_stalls = (m_stalls == 65535) ? 65535 : m_stalls + 1;
         if (v && exp_rdy) begin
            m_valid = 1'b1;
            m_instr = ins;
         end else if (hs) begin
            m_valid = 1'b0;
         end
      end
      cyc++;
      @(posedge clk);
   endtask

   initial begin
      logic [5:0] rnd_ins;
      rst = 1'b1; in_valid = 1'b1; instruction = 6'b0_010_01; out_ready = 1'b1;
      model_reset();

      // Reset with in_valid held high.
      step(1, 1, 6'b0_010_01, 1, 0);
      step(1, 1, 6'b0_010_01, 1, 1);
      step(0, 0, 6'b0_000_00, 1, 1);
      check("rst_out_valid", o_ov, 0);
      check("rst_we", o_we, 4'b0000);
      check("rst_in_ready", o_rdy, 1);
      check("rst_aku", o_aku, 0);
      check("rst_illegal", o_ill, 0);
      check("rst_opcode", o_opc, 0);
      check("rst_stall_count", o_sc, 0);

      // ALU op.
      step(0, 1, 6'b0_010_01, 1, 1);
      step(0, 0, 6'b0_000_00, 1, 1);
      check("alu_valid", o_ov, 1);
      check("alu_opc", o_opc, 3'b010);
      check("alu_aku", o_aku, 1);
      check("alu_addr", o_addr, 2'b01);
      check("alu_we", o_we, 4'b0000);

      // MOV op.
      step(0, 1, 6'b0_111_10, 1, 1);
      step(0, 0, 6'b0_000_00, 1, 1);
      check("mov_we", o_we, 4'b0100);
      check("mov_aku", o_aku, 0);
      check("mov_opc", o_opc, 3'b111);
      check("mov_illegal", o_ill, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 6'b0_000_00, 1, 1);

      // Read-after-write hazard on R2.
      step(0, 1, 6'b0_111_10, 1, 1);
      step(0, 1, 6'b0_000_10, 1, 1);
      check("raw_c1_ready", o_rdy, 0);
      step(0, 1, 6'b0_000_10, 1, 1);
      check("raw_c2_ready", o_rdy, 0);
      step(0, 1, 6'b0_000_10, 1, 1);
      check("raw_c3_ready", o_rdy, 0);
      step(0, 1, 6'b0_000_10, 1, 1);
      check("raw_c4_ready", o_rdy, 1);
`ifdef DEC_STALL_CNT_EN
      check("raw_stall_count", o_sc, 3);
`endif
      for (int k = 0; k < 4; k++) step(0, 0, 6'b0_000_00, 1, 1);

      // Contrast: reading a different register does not stall.
      step(0, 1, 6'b0_111_10, 1, 1);
      step(0, 1, 6'b0_000_01, 1, 1);
      check("noraw_ready", o_rdy, 1);
      for (int k = 0; k < 4; k++) step(0, 0, 6'b0_000_00, 1, 1);

      // Backpressure.
      step(0, 1, 6'b0_001_11, 1, 1);
      check("bp_accept", o_rdy, 1);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 6'b0_011_00, 0, 1);
         check("bp_ready", o_rdy, 0);
         check("bp_valid", o_ov, 1);
         check("bp_opc_hold", o_opc, 3'b001);
         check("bp_addr_hold", o_addr, 2'b11);
      end
      step(0, 1, 6'b0_011_00, 1, 1);
      check("bp_release_ready", o_rdy, 1);
      step(0, 0, 6'b0_000_00, 1, 1);
      check("bp_next_valid", o_ov, 1);
      check("bp_next_opc", o_opc, 3'b011);
      check("bp_next_addr", o_addr, 2'b00);

      // Illegal word.
      step(0, 1, 6'b1_011_00, 1, 1);
      step(0, 0, 6'b0_000_00, 1, 1);
      check("ill_flag", o_ill, 1);
      check("ill_aku", o_aku, 0);
      check("ill_we", o_we, 4'b0000);
      check("ill_opc", o_opc, 3'b011);

      // Reset in the middle of a hazard stall.
      for (int k = 0; k < 3; k++) step(0, 0, 6'b0_000_00, 1, 1);
      step(0, 1, 6'b0_111_01, 1, 1);
      step(0, 1, 6'b0_100_01, 1, 1);
      check("mid_stall1", o_rdy, 0);
      step(0, 1, 6'b0_100_01, 1, 1);
      check("mid_stall2", o_rdy, 0);
      step(1, 1, 6'b0_100_01, 1, 1);
      step(0, 1, 6'b0_100_01, 1, 1);
      check("post_rst_ready", o_rdy, 1);
      check("post_rst_valid", o_ov, 0);
      step(0, 0, 6'b0_000_00, 1, 1);
      check("post_rst_word_opc", o_opc, 3'b100);
      check("post_rst_word_addr", o_addr, 2'b01);

      // Randomized traffic, biased toward MOVs so hazards are frequent.
      for (int k = 0; k < 500; k++) begin
         rnd_ins[5]   = ($urandom_range(0, 7) == 0);
         rnd_ins[4:2] = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
         rnd_ins[1:0] = 2'($urandom);
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rnd_ins,
              $urandom_range(0, 3) != 0, 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
